// File: rtl/rom_load_pkg.sv
// Shared constants for ROM download sequencing: loader address map,
// one-hot region encodings and the load controller state type.
package rom_load_pkg;

    localparam logic [31:0] PROG_BASE       = 32'h0000_0000;
    localparam logic [31:0] PROG_LIMIT      = 32'h0000_1FFF;
    localparam logic [31:0] PLAYFIELD_BASE  = 32'h0000_2000;
    localparam logic [31:0] PLAYFIELD_LIMIT = 32'h0000_27FF;
    localparam logic [31:0] MOTION_BASE     = 32'h0000_2800;
    localparam logic [31:0] MOTION_LIMIT    = 32'h0000_2FFF;
    localparam logic [31:0] SYNC_BASE       = 32'h0000_3000;
    localparam logic [31:0] SYNC_LIMIT      = 32'h0000_30FF;

    localparam logic [3:0] REGION_NONE      = 4'b0000;
    localparam logic [3:0] REGION_PROG      = 4'b0001;
    localparam logic [3:0] REGION_PLAYFIELD = 4'b0010;
    localparam logic [3:0] REGION_MOTION    = 4'b0100;
    localparam logic [3:0] REGION_SYNC      = 4'b1000;

    typedef enum logic [1:0] {
        WAIT_ROM,
        LOAD,
        HOLD,
        RUN
    } load_state_t;

    function automatic logic in_region(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/rom_region_decode.sv
// Combinational loader-address decoder: byte address to one-hot ROM region
// select plus the offset inside that region. Addresses wider than 32 bits alias.
module rom_region_decode
    import rom_load_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              mapped,
    output logic [3:0]        sel,
    output logic [ADDR_W-1:0] offset
);

    logic [31:0] addr_ext;
    logic [31:0] base;

    assign addr_ext = 32'(addr);

    always_comb begin
        sel  = REGION_NONE;
        base = 32'd0;
        if (in_region(addr_ext, PROG_BASE, PROG_LIMIT)) begin
            sel  = REGION_PROG;
            base = PROG_BASE;
        end else if (in_region(addr_ext, PLAYFIELD_BASE, PLAYFIELD_LIMIT)) begin
            sel  = REGION_PLAYFIELD;
            base = PLAYFIELD_BASE;
        end else if (in_region(addr_ext, MOTION_BASE, MOTION_LIMIT)) begin
            sel  = REGION_MOTION;
            base = MOTION_BASE;
        end else if (in_region(addr_ext, SYNC_BASE, SYNC_LIMIT)) begin
            sel  = REGION_SYNC;
            base = SYNC_BASE;
        end
    end

    assign mapped = (sel != REGION_NONE);
    assign offset = ADDR_W'(addr_ext - base);

endmodule

// File: rtl/rom_load_ctrl.sv
// ROM download sequencer for the Ultra Tank core: registers loader writes into
// the ROM regions, keeps download statistics and owns the core reset.
module rom_load_ctrl
    import rom_load_pkg::*;
#(
    parameter int HOLD_CYCLES = 1024,
    parameter int ADDR_W      = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              user_reset,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_din,
    output logic [3:0]        rom_sel,
    output logic              core_reset_n,
    output logic              rom_valid,
    output logic [15:0]       byte_count,
    output logic [7:0]        checksum,
    output logic              addr_err
);

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    load_state_t       state;
    load_state_t       next_state;
    logic [15:0]       hold_cnt;
    logic              user_reset_q;

    logic              dec_mapped;
    logic [3:0]        dec_sel;
    logic [ADDR_W-1:0] dec_offset;

    logic              accept;
    logic              accept_mapped;
    logic              accept_unmapped;
    logic              load_entry;
    logic              hold_busy;
    logic              hold_done;

    rom_region_decode #(
        .ADDR_W (ADDR_W)
    ) u_decode (
        .addr   (dl_addr),
        .mapped (dec_mapped),
        .sel    (dec_sel),
        .offset (dec_offset)
    );

    // Any active strobe is accepted: dl_active=1 always lands in LOAD on this edge.
    assign accept          = dl_wr && dl_active;
    assign accept_mapped   = accept && dec_mapped;
    assign accept_unmapped = accept && !dec_mapped;
    assign load_entry      = dl_active && (state != LOAD);

    // The extra cycle of user_reset_q starts the hold count on the first edge
    // that sees user_reset low, so both release paths take the same time.
    assign hold_busy = user_reset || user_reset_q;
    assign hold_done = !hold_busy && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= WAIT_ROM;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            WAIT_ROM: begin
                if (dl_active) next_state = LOAD;
            end
            LOAD: begin
                if (!dl_active) begin
                    if (byte_count != 16'd0) next_state = HOLD;
                    else if (rom_valid)      next_state = RUN;
                    else                     next_state = WAIT_ROM;
                end
            end
            HOLD: begin
                if (dl_active)      next_state = LOAD;
                else if (hold_done) next_state = RUN;
            end
            RUN: begin
                if (dl_active)       next_state = LOAD;
                else if (user_reset) next_state = HOLD;
            end
            default: next_state = WAIT_ROM;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rom_we       <= 1'b0;
            rom_addr     <= '0;
            rom_din      <= 8'd0;
            rom_sel      <= REGION_NONE;
            core_reset_n <= 1'b0;
            rom_valid    <= 1'b0;
            hold_cnt     <= 16'd0;
            user_reset_q <= 1'b0;
        end else begin
            rom_we       <= accept_mapped;
            rom_sel      <= accept_mapped ? dec_sel : REGION_NONE;
            core_reset_n <= (state == RUN);
            user_reset_q <= user_reset;
            if (accept_mapped) begin
                rom_addr <= dec_offset;
                rom_din  <= dl_data;
            end
            if (state == LOAD && !dl_active && byte_count != 16'd0) begin
                rom_valid <= 1'b1;
            end
            if (state == HOLD && !hold_busy && next_state == HOLD) begin
                hold_cnt <= hold_cnt + 16'd1;
            end else begin
                hold_cnt <= 16'd0;
            end
        end
    end

    // Statistics restart on LOAD entry, folding in a byte accepted on that same edge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            byte_count <= 16'd0;
            checksum   <= 8'd0;
            addr_err   <= 1'b0;
        end else if (load_entry) begin
            byte_count <= accept_mapped ? 16'd1 : 16'd0;
            checksum   <= accept_mapped ? dl_data : 8'd0;
            addr_err   <= accept_unmapped;
        end else if (state == LOAD) begin
            if (accept_mapped && byte_count != 16'hFFFF) begin
                byte_count <= byte_count + 16'd1;
            end
            if (accept_mapped) begin
                checksum <= checksum + dl_data;
            end
            if (accept_unmapped) begin
                addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Self-checking bench for rom_load_ctrl: directed steps with random data and
// addresses, checked every cycle against a download-level reference model.
module tb_rom_load_ctrl;

    localparam int HOLD   = 24;
    localparam int ADDR_W = 16;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              user_reset;
    logic              dl_active;
    logic              dl_wr;
    logic [ADDR_W-1:0] dl_addr;
    logic [7:0]        dl_data;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_din;
    logic [3:0]        rom_sel;
    logic              core_reset_n;
    logic              rom_valid;
    logic [15:0]       byte_count;
    logic [7:0]        checksum;
    logic              addr_err;

    int checks   = 0;
    int failures = 0;

    int       m_count;
    int       m_sum;
    bit       m_err;
    bit       m_valid;
    bit       m_prev_active;
    bit       exp_we;
    bit [3:0] exp_sel;
    int       exp_off;
    int       exp_data;
    int       we_pulses;

    rom_load_ctrl #(
        .HOLD_CYCLES (HOLD),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .user_reset   (user_reset),
        .dl_active    (dl_active),
        .dl_wr        (dl_wr),
        .dl_addr      (dl_addr),
        .dl_data      (dl_data),
        .rom_we       (rom_we),
        .rom_addr     (rom_addr),
        .rom_din      (rom_din),
        .rom_sel      (rom_sel),
        .core_reset_n (core_reset_n),
        .rom_valid    (rom_valid),
        .byte_count   (byte_count),
        .checksum     (checksum),
        .addr_err     (addr_err)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic void refRegion(input int a, output bit [3:0] sel, output int off);
        sel = 4'b0000;
        off = 0;
        if (a < 'h2000) begin
            sel = 4'b0001; off = a;
        end else if (a < 'h2800) begin
            sel = 4'b0010; off = a - 'h2000;
        end else if (a < 'h3000) begin
            sel = 4'b0100; off = a - 'h2800;
        end else if (a < 'h3100) begin
            sel = 4'b1000; off = a - 'h3000;
        end
    endfunction

    function automatic logic [15:0] randAddr(input bit mapped_only);
        int r;
        r = mapped_only ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 4));
        case (r)
            0:       return 16'($urandom_range(0, 'h1FFF));
            1:       return 16'($urandom_range('h2000, 'h27FF));
            2:       return 16'($urandom_range('h2800, 'h2FFF));
            3:       return 16'($urandom_range('h3000, 'h30FF));
            default: return 16'($urandom_range('h3100, 'hFFFF));
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare 1 ns later.
    task automatic applyStimulus(input bit act, input bit wr,
                                 input logic [15:0] addr, input logic [7:0] data);
        bit [3:0] sel;
        int       off;
        dl_active = act;
        dl_wr     = wr;
        dl_addr   = addr;
        dl_data   = data;
        @(posedge clk_sys);
        exp_we  = 1'b0;
        exp_sel = 4'b0000;
        if (reset) begin
            m_count       = 0;
            m_sum         = 0;
            m_err         = 1'b0;
            m_valid       = 1'b0;
            m_prev_active = 1'b0;
        end else begin
            if (m_prev_active && !act && m_count != 0) m_valid = 1'b1;
            if (act && !m_prev_active) begin
                m_count = 0;
                m_sum   = 0;
                m_err   = 1'b0;
            end
            if (act && wr) begin
                refRegion(int'(addr), sel, off);
                if (sel != 4'b0000) begin
                    exp_we   = 1'b1;
                    exp_sel  = sel;
                    exp_off  = off;
                    exp_data = int'(data);
                    if (m_count < 65535) m_count++;
                    m_sum = (m_sum + int'(data)) % 256;
                end else begin
                    m_err = 1'b1;
                end
            end
            m_prev_active = act;
        end
        #1;
        if (rom_we === 1'b1) we_pulses++;
        checkOutput("rom_we", 32'(rom_we), 32'(exp_we));
        checkOutput("rom_sel", 32'(rom_sel), 32'(exp_sel));
        if (exp_we) begin
            checkOutput("rom_addr", 32'(rom_addr), 32'(exp_off));
            checkOutput("rom_din", 32'(rom_din), 32'(exp_data));
        end
        checkOutput("byte_count", 32'(byte_count), 32'(m_count));
        checkOutput("checksum", 32'(checksum), 32'(m_sum));
        checkOutput("addr_err", 32'(addr_err), 32'(m_err));
        checkOutput("rom_valid", 32'(rom_valid), 32'(m_valid));
    endtask

    // Counts edges until core_reset_n rises, bounded so a stuck DUT still finishes.
    task automatic waitRelease(input string tag, input int expected);
        int n = 0;
        while (core_reset_n !== 1'b1 && n < 4 * HOLD + 20) begin
            applyStimulus(1'b0, 1'b0, 16'h0, 8'h0);
            n++;
        end
        checkOutput(tag, 32'(n), 32'(expected));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_rom_we"}, 32'(rom_we), 32'd0);
        checkOutput({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        checkOutput({tag, "_rom_din"}, 32'(rom_din), 32'd0);
        checkOutput({tag, "_rom_sel"}, 32'(rom_sel), 32'd0);
        checkOutput({tag, "_core_reset_n"}, 32'(core_reset_n), 32'd0);
        checkOutput({tag, "_rom_valid"}, 32'(rom_valid), 32'd0);
        checkOutput({tag, "_byte_count"}, 32'(byte_count), 32'd0);
        checkOutput({tag, "_checksum"}, 32'(checksum), 32'd0);
        checkOutput({tag, "_addr_err"}, 32'(addr_err), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        user_reset    = 1'b0;
        dl_active     = 1'b0;
        dl_wr         = 1'b0;
        dl_addr       = '0;
        dl_data       = 8'h0;
        m_count       = 0;
        m_sum         = 0;
        m_err         = 1'b0;
        m_valid       = 1'b0;
        m_prev_active = 1'b0;
        we_pulses     = 0;

        // Reset, then a long idle stretch with stray strobes while dl_active is low.
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0);
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0);
        checkReset("reset");
        reset = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
            checkOutput("idle_core_reset_n", 32'(core_reset_n), 32'd0);
        end

        // Sixteen program bytes, one per cycle; first strobe arrives with dl_active.
        we_pulses = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, 16'(i), 8'(i + 1));
        end
        applyStimulus(1'b0, 1'b1, 16'h0010, 8'h77);
        checkOutput("load16_pulses", 32'(we_pulses), 32'd16);
        checkOutput("load16_count", 32'(byte_count), 32'd16);
        checkOutput("load16_checksum", 32'(checksum), 32'h88);
        checkOutput("load16_core_reset_n", 32'(core_reset_n), 32'd0);
        waitRelease("load16_release_cycles", HOLD + 1);
        checkOutput("load16_rom_valid", 32'(rom_valid), 32'd1);

        // Motion-object write then an unmapped write.
        applyStimulus(1'b1, 1'b1, 16'h2805, 8'hAA);
        checkOutput("mo_rom_sel", 32'(rom_sel), 32'b0100);
        checkOutput("mo_rom_addr", 32'(rom_addr), 32'h0005);
        checkOutput("mo_rom_din", 32'(rom_din), 32'hAA);
        applyStimulus(1'b1, 1'b1, 16'h4000, 8'h55);
        checkOutput("unmapped_rom_we", 32'(rom_we), 32'd0);
        checkOutput("unmapped_addr_err", 32'(addr_err), 32'd1);
        applyStimulus(1'b1, 1'b0, 16'h0, 8'h0);
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0);
        checkOutput("err_checksum", 32'(checksum), 32'hAA);
        checkOutput("err_count", 32'(byte_count), 32'd1);
        waitRelease("err_release_cycles", HOLD + 1);

        // User reset pulse while running.
        user_reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0);
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0);
        checkOutput("ureset_core_reset_n", 32'(core_reset_n), 32'd0);
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0);
        user_reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0);
        waitRelease("ureset_release_cycles", HOLD + 1);
        checkOutput("ureset_count", 32'(byte_count), 32'd1);
        checkOutput("ureset_checksum", 32'(checksum), 32'hAA);
        checkOutput("ureset_addr_err", 32'(addr_err), 32'd1);

        // Random mixed download with gaps, then a re-download started during HOLD.
        applyStimulus(1'b1, 1'b1, 16'h0000, 8'($urandom));
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 3) != 0), randAddr(1'b0), 8'($urandom));
        end
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 16'h0, 8'h0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, randAddr(1'b1), 8'($urandom));
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0);
        checkOutput("rehold_count", 32'(byte_count), 32'd4);
        waitRelease("rehold_release_cycles", HOLD + 1);

        // Reset in the middle of a 200-byte download, then a complete download.
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, 1'b1, randAddr(1'b1), 8'($urandom));
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, randAddr(1'b1), 8'($urandom));
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0);
        checkReset("midreset");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 16'h0, 8'h0);
        for (int i = 0; i < 200; i++) applyStimulus(1'b1, 1'b1, randAddr(1'b1), 8'($urandom));
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0);
        checkOutput("reload_count", 32'(byte_count), 32'd200);
        waitRelease("reload_release_cycles", HOLD + 1);
        checkOutput("reload_core_reset_n", 32'(core_reset_n), 32'd1);

        // Empty re-download while running returns straight to RUN.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 16'($urandom), 8'h0);
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0);
        checkOutput("empty_count", 32'(byte_count), 32'd0);
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0);
        checkOutput("empty_core_reset_n", 32'(core_reset_n), 32'd1);
        checkOutput("empty_rom_valid", 32'(rom_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
